seg7_scan_driver: RTL

//   Output-side board interface: drives a 4-digit common-anode 7-segment display from parallel data.

---
 rtl/seg7_scan_driver_if.sv | 22 ++
 rtl/seg7_scan_driver.sv | 110 +++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bus between a display data source and seg7_scan_driver.
// Handshake: load is a one-cycle strobe, always accepted (no ready); value/dp_in/blank/blink are sampled with it.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        load;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    modport master (
        output value, dp_in, blank, blink, load,
        input  an, seg, frame_start
    );

    modport slave (
        input  value, dp_in, blank, blink, load,
        output an, seg, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with double-buffered data,
// per-digit blank/blink/dp and an anti-ghost dead time at the start of each slot.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 500,
    parameter int BLINK_FRAMES = 125
) (
    input logic clk,
    input logic rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } frame_t;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          blink_on;
    logic          pending;
    frame_t        pend;
    frame_t        disp;
    frame_t        in_frame;

    logic          tick;
    logic          boundary;
    logic          dark;
    logic [3:0]    nib;
    logic [7:0]    seg_next;
    logic [3:0]    an_next;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        in_frame = '{value: bus.value, dp: bus.dp_in, blank: bus.blank, blink: bus.blink};
        tick     = (presc == PW'(SCAN_DIV - 1));
        boundary = tick && (idx == 2'd3);
        nib      = disp.value[{idx, 2'b00} +: 4];
        // Dark digits suppress the decimal point as well.
        dark     = disp.blank[idx] | (disp.blink[idx] & ~blink_on);
        seg_next = dark ? 8'hFF : {~disp.dp[idx], hex7(nib)};
        an_next  = (presc >= PW'(DEAD_CYC)) ? ~(4'b0001 << idx) : 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc           <= '0;
            idx             <= '0;
            fcnt            <= '0;
            blink_on        <= 1'b1;
            pending         <= 1'b0;
            pend            <= '0;
            disp            <= '0;
            bus.an          <= 4'hF;
            bus.seg         <= 8'hFF;
            bus.frame_start <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= idx + 2'd1;

            // A load on the boundary tick bypasses the pending buffer.
            if (boundary) begin
                if (bus.load)     disp <= in_frame;
                else if (pending) disp <= pend;
                pending <= 1'b0;
            end else if (bus.load) begin
                pend    <= in_frame;
                pending <= 1'b1;
            end

            if (boundary) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            bus.frame_start <= boundary;
            bus.seg         <= seg_next;
            bus.an          <= an_next;
        end
    end
endmodule
